// File: rtl/stage_sequencer.sv
// stage_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM with memory timeout and retire counter.
// Strobes fire in the cycle a state exits and are gated by stall_i; request levels follow the state.
// Optional STAGE_SEQ_ILLEGAL_TRAP_EN: unknown opcodes trap to HALT and raise a sticky illegal_o.

`ifndef DECODE_R_TYPE
`define DECODE_R_TYPE 7'b0110011
`endif
`ifndef DECODE_I_TYPE
`define DECODE_I_TYPE 7'b0010011
`endif
`ifndef DECODE_L_TYPE
`define DECODE_L_TYPE 7'b0000011
`endif
`ifndef DECODE_S_TYPE
`define DECODE_S_TYPE 7'b0100011
`endif

module stage_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic [31:0]      ir_i,
  input  logic             imem_ack_i,
  input  logic             dmem_ack_i,
  output logic             fetch_req_o,
  output logic             ir_load_o,
  output logic             decode_en_o,
  output logic             exec_en_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic             wd_q_readin_o,
  output logic             rf_we_o,
  output logic             pc_load_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             fault_o
`ifdef STAGE_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic             illegal_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam int TMO_W = $clog2(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state;
  logic [TMO_W-1:0] tmo;
  logic             ack_pend;
  logic             mem_we;

  logic [6:0] opcode;
  logic       op_ri, op_l, op_s, op_unknown;
  logic       waiting, ack_in, ack_seen, ack_take, tmo_hit, run, wb_fire;
  logic       unused_ir;

  assign unused_ir = ^ir_i[31:7];

  // Opcode steering and memory-handshake qualification for the current state
  always_comb begin
    opcode     = ir_i[6:0];
    op_ri      = (opcode == `DECODE_R_TYPE) || (opcode == `DECODE_I_TYPE);
    op_l       = (opcode == `DECODE_L_TYPE);
    op_s       = (opcode == `DECODE_S_TYPE);
    op_unknown = !(op_ri || op_l || op_s);
    run        = !stall_i;
    waiting    = (state == S_FETCH) || (state == S_MEM);
    ack_in     = 1'b0;
    if (state == S_FETCH)    ack_in = imem_ack_i;
    else if (state == S_MEM) ack_in = dmem_ack_i;
    ack_seen   = ack_in || ack_pend;
    ack_take   = waiting && ack_seen && run;
    // Timeout is evaluated even under stall so a dead bus still faults; any ack wins.
    tmo_hit    = waiting && !ack_seen && (tmo == TMO_LAST);
    wb_fire    = (state == S_WB) && run;
  end

  // Output decode from the state register; strobes only in the exiting, unstalled cycle
  always_comb begin
    state_o       = state;
    fetch_req_o   = (state == S_FETCH);
    ir_load_o     = (state == S_FETCH) && ack_take;
    decode_en_o   = (state == S_DECODE) && run;
    exec_en_o     = (state == S_EXEC) && run;
    dmem_req_o    = (state == S_MEM);
    dmem_we_o     = (state == S_MEM) && mem_we;
    wd_q_readin_o = wb_fire;
    rf_we_o       = wb_fire;
    pc_load_o     = wb_fire || ((state == S_MEM) && ack_take && mem_we);
`ifndef STAGE_SEQ_ILLEGAL_TRAP_EN
    // Unknown opcode retires as a NOP straight out of EXEC
    if ((state == S_EXEC) && run && op_unknown) pc_load_o = 1'b1;
`endif
  end

  // Sequencer state, timeout counter, pending ack, retire counter and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      tmo          <= '0;
      ack_pend     <= 1'b0;
      mem_we       <= 1'b0;
      retire_cnt_o <= '0;
      fault_o      <= 1'b0;
`ifdef STAGE_SEQ_ILLEGAL_TRAP_EN
      illegal_o    <= 1'b0;
`endif
    end else begin
      // tmo saturates while waiting and idles at zero elsewhere; transitions zero it below
      if (!waiting)              tmo <= '0;
      else if (tmo != TMO_LAST)  tmo <= tmo + TMO_W'(1);
      if (waiting && stall_i && ack_in) ack_pend <= 1'b1;
      if (pc_load_o) retire_cnt_o <= retire_cnt_o + CNT_W'(1);

      case (state)
        S_IDLE: begin
          if (start_i) state <= S_FETCH;
        end
        S_FETCH: begin
          if (ack_take) begin
            state    <= S_DECODE;
            tmo      <= '0;
            ack_pend <= 1'b0;
          end else if (tmo_hit) begin
            state    <= S_HALT;
            tmo      <= '0;
            fault_o  <= 1'b1;
          end
        end
        S_DECODE: begin
          if (run) state <= S_EXEC;
        end
        S_EXEC: begin
          if (run) begin
            if (op_ri) begin
              state  <= S_WB;
            end else if (op_l) begin
              state  <= S_MEM;
              mem_we <= 1'b0;
            end else if (op_s) begin
              state  <= S_MEM;
              mem_we <= 1'b1;
            end else begin
`ifdef STAGE_SEQ_ILLEGAL_TRAP_EN
              state     <= S_HALT;
              illegal_o <= 1'b1;
`else
              state     <= S_FETCH;
`endif
            end
          end
        end
        S_MEM: begin
          if (ack_take) begin
            state    <= mem_we ? S_FETCH : S_WB;
            tmo      <= '0;
            ack_pend <= 1'b0;
          end else if (tmo_hit) begin
            state    <= S_HALT;
            tmo      <= '0;
            fault_o  <= 1'b1;
          end
        end
        S_WB: begin
          if (run) state <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer: scripted per-cycle stimulus with a queue of expected outputs.
// Each driven cycle pushes the expected output vector; a negedge monitor pops and compares.
// Counters and sticky flags are checked directly at instruction boundaries.

module tb_stage_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

  // Output bit masks: fetch_req, ir_load, decode_en, exec_en, dmem_req, dmem_we, wd_q, rf_we, pc_load
  localparam logic [8:0] O_NONE = 9'h000, O_FR = 9'h100, O_IL = 9'h080, O_DE = 9'h040,
                         O_EE = 9'h020, O_DR = 9'h010, O_DW = 9'h008, O_WQ = 9'h004,
                         O_RW = 9'h002, O_PL = 9'h001;

  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_L = 7'h03, OP_S = 7'h23, OP_BAD = 7'h7F;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stall = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [31:0] ir = 32'h0;

  logic        fetch_req, ir_load, decode_en, exec_en, dmem_req, dmem_we;
  logic        wd_q_readin, rf_we, pc_load, fault;
  logic [2:0]  state;
  logic [31:0] retire_cnt;
`ifdef STAGE_SEQ_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  logic [11:0] obs;
  logic [11:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  stage_sequencer #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(rst), .start_i(start), .stall_i(stall), .ir_i(ir),
    .imem_ack_i(imem_ack), .dmem_ack_i(dmem_ack),
    .fetch_req_o(fetch_req), .ir_load_o(ir_load), .decode_en_o(decode_en),
    .exec_en_o(exec_en), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we),
    .wd_q_readin_o(wd_q_readin), .rf_we_o(rf_we), .pc_load_o(pc_load),
    .state_o(state), .retire_cnt_o(retire_cnt), .fault_o(fault)
`ifdef STAGE_SEQ_ILLEGAL_TRAP_EN
    , .illegal_o(illegal)
`endif
  );

  assign obs = {state, fetch_req, ir_load, decode_en, exec_en, dmem_req, dmem_we,
                wd_q_readin, rf_we, pc_load};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: one expected vector per driven cycle
  always @(negedge clk) begin : monitor
    logic [11:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("cycle_outputs{state,fr,il,de,ee,dr,dw,wq,rw,pl}", {20'h0, obs}, {20'h0, e});
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic step(input logic st, input logic sl, input logic ia, input logic da,
                      input logic [2:0] s, input logic [8:0] o);
    start    = st;
    stall    = sl;
    imem_ack = ia;
    dmem_ack = da;
    exp_q.push_back({s, o});
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int waits);
    for (int i = 0; i < waits; i++) step(0, 0, 0, 0, ST_FETCH, O_FR);
    step(0, 0, 1, 0, ST_FETCH, O_FR | O_IL);
  endtask

  task automatic do_decode_exec(input logic nop_retire);
    step(0, 0, 0, 0, ST_DECODE, O_DE);
    step(0, 0, 0, 0, ST_EXEC, nop_retire ? (O_EE | O_PL) : O_EE);
  endtask

  task automatic do_wb();
    step(0, 0, 0, 0, ST_WB, O_WQ | O_RW | O_PL);
  endtask

  task automatic do_mem(input int waits, input logic we);
    for (int i = 0; i < waits; i++) step(0, 0, 0, 0, ST_MEM, we ? (O_DR | O_DW) : O_DR);
    step(0, 0, 0, 1, ST_MEM, we ? (O_DR | O_DW | O_PL) : O_DR);
  endtask

  task automatic set_op(input logic [6:0] op);
    ir = {25'($urandom), op};
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    start    = 1'b0;
    stall    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #2;
    check("reset_outputs", {20'h0, obs}, 32'h0);
    check("reset_retire", retire_cnt, 32'h0);
    check("reset_fault", {31'h0, fault}, 32'h0);
`ifdef STAGE_SEQ_ILLEGAL_TRAP_EN
    check("reset_illegal", {31'h0, illegal}, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

  initial begin : stimulus
    #1;
    do_reset();

    // R-type with immediate imem ack: IDLE, FETCH, DECODE, EXEC, WB
    set_op(OP_R);
    step(1, 0, 0, 0, ST_IDLE, O_NONE);
    do_fetch(0);
    do_decode_exec(1'b0);
    do_wb();
    check("retire_after_rtype", retire_cnt, 32'd1);

    // Load: dmem ack in the third MEM cycle, then WB
    set_op(OP_L);
    do_fetch(0);
    do_decode_exec(1'b0);
    do_mem(2, 1'b0);
    do_wb();
    check("retire_after_load", retire_cnt, 32'd2);

    // Store: retires from MEM, back to FETCH with no rf write
    set_op(OP_S);
    do_fetch(0);
    do_decode_exec(1'b0);
    do_mem(1, 1'b1);
    check("retire_after_store", retire_cnt, 32'd3);

    // Stall 5 cycles in FETCH with ack on stall cycle 2; then a 1-cycle EXEC stall
    set_op(OP_I);
    for (int k = 1; k <= 5; k++) step(1, 1, (k == 2), 0, ST_FETCH, O_FR);
    step(0, 0, 0, 0, ST_FETCH, O_FR | O_IL);
    step(0, 0, 0, 0, ST_DECODE, O_DE);
    step(0, 1, 0, 0, ST_EXEC, O_NONE);
    step(0, 0, 0, 0, ST_EXEC, O_EE);
    do_wb();
    check("retire_after_stall", retire_cnt, 32'd4);

    // Ack arriving on the last timeout cycle still wins
    set_op(OP_R);
    do_fetch(15);
    do_decode_exec(1'b0);
    do_wb();
    check("retire_after_late_ack", retire_cnt, 32'd5);
    check("no_fault_late_ack", {31'h0, fault}, 32'h0);

    // Unknown opcode
    set_op(OP_BAD);
    do_fetch(0);
`ifdef STAGE_SEQ_ILLEGAL_TRAP_EN
    do_decode_exec(1'b0);
    step(1, 0, 1, 1, ST_HALT, O_NONE);
    check("illegal_set", {31'h0, illegal}, 32'h1);
    check("retire_after_trap", retire_cnt, 32'd5);
`else
    do_decode_exec(1'b1);
    step(0, 0, 0, 0, ST_FETCH, O_FR);
    check("retire_after_nop", retire_cnt, 32'd6);
`endif
    check("no_fault_after_unknown", {31'h0, fault}, 32'h0);

    // Reset mid-instruction, then imem timeout into HALT
    do_reset();
    set_op(OP_R);
    step(1, 0, 0, 0, ST_IDLE, O_NONE);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, ST_FETCH, O_FR);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, ST_HALT, O_NONE);
    check("fault_after_timeout", {31'h0, fault}, 32'h1);
    check("retire_in_halt", retire_cnt, 32'd0);

    // Reset clears HALT and the sticky fault
    do_reset();
    step(0, 0, 0, 0, ST_IDLE, O_NONE);
    step(0, 0, 0, 0, ST_IDLE, O_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
